// File: rtl/reg_bank_pkg.sv
// Shared defaults and the clear-sequencer state type for the register bank.
package reg_bank_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_bank_if.sv
// Request/response bundle of the register bank: one write port, two read ports, bulk clear.
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rd_valid;
    logic              clr_req;
    logic              busy;
    logic              wr_drop;
    logic              addr_err;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rs_addr, rt_addr, clr_req,
        input  rs_data, rt_data, rd_valid, busy, wr_drop, addr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rs_addr, rt_addr, clr_req,
        output rs_data, rt_data, rd_valid, busy, wr_drop, addr_err
    );

endinterface

// File: rtl/reg_bank_clr_seq.sv
// Bulk-clear sequencer: walks entries 1..NUM_REGS, one per clock, while busy.
module reg_bank_clr_seq
    import reg_bank_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clr_req is only looked at in IDLE, so a request during CLEAR is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                if (cnt_q == ADDR_W'(NUM_REGS)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        clr_en   = (state_q == CLEAR);
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/reg_bank.sv
// Two-read/one-write register bank with hardwired-zero address 0, write bypass
// and a sequenced bulk clear.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic      clk,
    input  logic      rst_n,
    reg_bank_if.slave bus
);

    if (NUM_REGS > (2 ** ADDR_W) - 1) begin : g_addr_chk
        $error("reg_bank: ADDR_W=%0d cannot encode NUM_REGS=%0d", ADDR_W, NUM_REGS);
    end

    logic [DATA_W-1:0] mem_q [1:NUM_REGS];
    logic [DATA_W-1:0] mem_d [1:NUM_REGS];
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] rs_sel, rt_sel;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_drop_q, wr_drop_d;
    logic              addr_err_q, addr_err_d;
    logic              busy, clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok, wr_acc;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a != '0) && (a <= ADDR_W'(NUM_REGS));
    endfunction

    function automatic logic out_range(input logic [ADDR_W-1:0] a);
        return a > ADDR_W'(NUM_REGS);
    endfunction

    reg_bank_clr_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // Address 0 and out-of-range addresses match no entry and read as zero.
    always_comb begin
        rs_sel = '0;
        rt_sel = '0;
        for (int i = 1; i <= NUM_REGS; i++) begin
            if (bus.rs_addr == ADDR_W'(i)) rs_sel = mem_q[i];
            if (bus.rt_addr == ADDR_W'(i)) rt_sel = mem_q[i];
        end
    end

    always_comb begin
        wr_ok  = bus.wr_en && in_range(bus.wr_addr);
        wr_acc = wr_ok && !busy;

        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        if (bus.rd_en) begin
            rs_data_d = (wr_acc && (bus.wr_addr == bus.rs_addr)) ? bus.wr_data : rs_sel;
            rt_data_d = (wr_acc && (bus.wr_addr == bus.rt_addr)) ? bus.wr_data : rt_sel;
        end
        rd_valid_d = bus.rd_en;
        wr_drop_d  = wr_ok && busy;
        addr_err_d = (bus.rd_en && (out_range(bus.rs_addr) || out_range(bus.rt_addr)))
                   || (bus.wr_en && out_range(bus.wr_addr));
    end

    // Writes are blocked while busy, so a write and a clear never hit the same entry.
    always_comb begin
        mem_d = mem_q;
        for (int i = 1; i <= NUM_REGS; i++) begin
            if (wr_acc && (bus.wr_addr == ADDR_W'(i))) mem_d[i] = bus.wr_data;
            if (clr_en && (clr_addr == ADDR_W'(i)))    mem_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NUM_REGS; i++) mem_q[i] <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            rd_valid_q <= rd_valid_d;
            wr_drop_q  <= wr_drop_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.rs_data  = rs_data_q;
    assign bus.rt_data  = rt_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy;
    assign bus.wr_drop  = wr_drop_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: default build checked every cycle against a behavioural
// model plus literal expectations; a 32-bit/31-entry build gets directed checks.
module tb_reg_bank;

    localparam int NREG = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    reg_bank_if #(.ADDR_W(5), .DATA_W(8))  bus  ();
    reg_bank_if #(.ADDR_W(5), .DATA_W(32)) bus2 ();

    reg_bank #(.DATA_W(8), .NUM_REGS(16), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    reg_bank #(.DATA_W(32), .NUM_REGS(31), .ADDR_W(5)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default build ----------------
    logic [7:0] mm [1:NREG];
    logic [7:0] e_rs, e_rt;
    logic       e_vld, e_drop, e_err;
    int         clr_left;   // clock edges of clearing still to come
    logic       e_busy;

    assign e_busy = (clr_left > 0);

    function automatic logic inr(input int a);
        return (a >= 1) && (a <= NREG);
    endfunction

    function automatic logic wr_taken();
        return bus.wr_en && (clr_left == 0) && inr(int'(bus.wr_addr));
    endfunction

    function automatic logic [7:0] peek(input int a);
        if (wr_taken() && (int'(bus.wr_addr) == a)) return bus.wr_data;
        if (inr(a)) return mm[a];
        return 8'h00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NREG; i++) mm[i] <= 8'h00;
            e_rs     <= 8'h00;
            e_rt     <= 8'h00;
            e_vld    <= 1'b0;
            e_drop   <= 1'b0;
            e_err    <= 1'b0;
            clr_left <= 0;
        end else begin
            if (bus.rd_en) begin
                e_rs <= peek(int'(bus.rs_addr));
                e_rt <= peek(int'(bus.rt_addr));
            end
            e_vld  <= bus.rd_en;
            e_drop <= bus.wr_en && (clr_left > 0) && inr(int'(bus.wr_addr));
            e_err  <= (bus.rd_en && ((int'(bus.rs_addr) > NREG) || (int'(bus.rt_addr) > NREG)))
                   || (bus.wr_en && (int'(bus.wr_addr) > NREG));
            if (wr_taken()) mm[int'(bus.wr_addr)] <= bus.wr_data;
            if (clr_left > 0) begin
                mm[NREG - clr_left + 1] <= 8'h00;
                clr_left <= clr_left - 1;
            end else if (bus.clr_req) begin
                clr_left <= NREG;
            end
        end
    end

    always @(negedge clk) begin
        chk("rs_data",  32'(bus.rs_data),  32'(e_rs));
        chk("rt_data",  32'(bus.rt_data),  32'(e_rt));
        chk("rd_valid", 32'(bus.rd_valid), 32'(e_vld));
        chk("busy",     32'(bus.busy),     32'(e_busy));
        chk("wr_drop",  32'(bus.wr_drop),  32'(e_drop));
        chk("addr_err", 32'(bus.addr_err), 32'(e_err));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic we, input int wa, input logic [7:0] wd,
                        input logic re, input int rs, input int rt, input logic cr);
        bus.wr_en   = we;
        bus.wr_addr = 5'(wa);
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rs_addr = 5'(rs);
        bus.rt_addr = 5'(rt);
        bus.clr_req = cr;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic step2(input logic we, input int wa, input logic [31:0] wd,
                         input logic re, input int rs, input int rt, input logic cr);
        bus2.wr_en   = we;
        bus2.wr_addr = 5'(wa);
        bus2.wr_data = wd;
        bus2.rd_en   = re;
        bus2.rs_addr = 5'(rs);
        bus2.rt_addr = 5'(rt);
        bus2.clr_req = cr;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int g;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_en = 1'b0;
        bus.rs_addr = '0; bus.rt_addr = '0; bus.clr_req = 1'b0;
        bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.rd_en = 1'b0;
        bus2.rs_addr = '0; bus2.rt_addr = '0; bus2.clr_req = 1'b0;

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst rs_data",  32'(bus.rs_data),  32'h0);
        chk("rst rt_data",  32'(bus.rt_data),  32'h0);
        chk("rst rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst busy",     32'(bus.busy),     32'h0);
        chk("rst wr_drop",  32'(bus.wr_drop),  32'h0);
        chk("rst addr_err", 32'(bus.addr_err), 32'h0);
        rst_n = 1'b1;
        idle();

        // write A5 to reg 3, then read rs=3 / rt=0
        step(1'b1, 3, 8'hA5, 1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 8'h00, 1'b1, 3, 0, 1'b0);
        chk("rd3 rs_data",  32'(bus.rs_data),  32'hA5);
        chk("rd3 rt_data",  32'(bus.rt_data),  32'h00);
        chk("rd3 rd_valid", 32'(bus.rd_valid), 32'h1);
        idle();
        chk("hold rs_data",  32'(bus.rs_data),  32'hA5);
        chk("idle rd_valid", 32'(bus.rd_valid), 32'h0);

        // same-cycle write/read bypass
        step(1'b1, 5, 8'h3C, 1'b1, 5, 5, 1'b0);
        chk("bypass rs", 32'(bus.rs_data), 32'h3C);
        chk("bypass rt", 32'(bus.rt_data), 32'h3C);

        // address 0 write: ignored, no bypass, no error
        step(1'b1, 0, 8'hAB, 1'b1, 0, 3, 1'b0);
        chk("zero rs",       32'(bus.rs_data),  32'h00);
        chk("zero addr_err", 32'(bus.addr_err), 32'h0);

        // out-of-range write and read
        step(1'b1, 17, 8'h55, 1'b1, 20, 3, 1'b0);
        chk("oor addr_err", 32'(bus.addr_err), 32'h1);
        chk("oor rs_data",  32'(bus.rs_data),  32'h00);
        chk("oor rt_data",  32'(bus.rt_data),  32'hA5);
        idle();
        chk("oor addr_err end", 32'(bus.addr_err), 32'h0);
        step(1'b0, 0, 8'h00, 1'b1, 3, 16, 1'b0);
        chk("oor reg3 kept", 32'(bus.rs_data), 32'hA5);

        // fill all entries, then bulk clear
        for (int i = 1; i <= NREG; i++) step(1'b1, i, 8'(8'h10 + i), 1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b1);
        n = bus.busy ? 1 : 0;
        step(1'b1, 4, 8'hEE, 1'b1, 4, 16, 1'b0);
        if (bus.busy) n++;
        chk("busy wr_drop",  32'(bus.wr_drop), 32'h1);
        chk("busy rd reg4",  32'(bus.rs_data), 32'h14);
        chk("busy rd reg16", 32'(bus.rt_data), 32'h20);
        step(1'b1, 0, 8'h77, 1'b0, 0, 0, 1'b1);
        if (bus.busy) n++;
        chk("busy wr0 no drop", 32'(bus.wr_drop), 32'h0);
        g = 0;
        while (bus.busy === 1'b1 && g < 64) begin
            idle();
            g++;
            if (bus.busy) n++;
        end
        chk("clear busy cycles", 32'(n), 32'd16);
        for (int i = 0; i <= NREG; i += 2) step(1'b0, 0, 8'h00, 1'b1, i, i + 1, 1'b0);
        step(1'b0, 0, 8'h00, 1'b1, 4, 9, 1'b0);
        chk("cleared reg4", 32'(bus.rs_data), 32'h00);

        // reset in the middle of a clear, with a write taken alongside clr_req
        for (int i = 1; i <= NREG; i++) step(1'b1, i, 8'(8'hF0 ^ i), 1'b0, 0, 0, 1'b0);
        step(1'b1, 9, 8'h99, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) idle();
        step(1'b0, 0, 8'h00, 1'b1, 16, 9, 1'b0);
        chk("midclr reg16", 32'(bus.rs_data), 32'hE0);
        chk("midclr reg9",  32'(bus.rt_data), 32'h99);
        chk("midclr busy",  32'(bus.busy),    32'h1);
        bus.rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst rs_data",  32'(bus.rs_data),  32'h0);
        chk("arst rt_data",  32'(bus.rt_data),  32'h0);
        chk("arst rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("arst busy",     32'(bus.busy),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post-rst busy", 32'(bus.busy), 32'h0);
        for (int i = 1; i <= NREG; i += 2) step(1'b0, 0, 8'h00, 1'b1, i, i + 1, 1'b0);
        step(1'b0, 0, 8'h00, 1'b1, 16, 9, 1'b0);
        chk("post-rst reg16", 32'(bus.rs_data), 32'h00);
        chk("post-rst reg9",  32'(bus.rt_data), 32'h00);
        idle();

        // wide build: 32-bit data, 31 entries
        step2(1'b1, 31, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0);
        step2(1'b0, 0, 32'h0, 1'b1, 31, 30, 1'b0);
        chk("w32 rs reg31",  bus2.rs_data,        32'hDEADBEEF);
        chk("w32 rt reg30",  bus2.rt_data,        32'h0);
        chk("w32 rd_valid",  32'(bus2.rd_valid),  32'h1);
        step2(1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b1);
        bus2.clr_req = 1'b0;
        n = bus2.busy ? 1 : 0;
        g = 0;
        while (bus2.busy === 1'b1 && g < 64) begin
            @(negedge clk);
            g++;
            if (bus2.busy) n++;
        end
        chk("w32 clear busy cycles", 32'(n), 32'd31);
        step2(1'b0, 0, 32'h0, 1'b1, 31, 1, 1'b0);
        chk("w32 cleared reg31", bus2.rs_data, 32'h0);
        step2(1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1, "timeout");
    end

endmodule
